// File: rtl/mux_scan_pkg.sv
// Shared state encoding and defaults for the mux scan sampler.
// Optional parity output is enabled with MUX_SCAN_SAMPLER_PARITY_EN.
package mux_scan_pkg;

    localparam int DEF_SEL_W  = 3;
    localparam int DEF_SETTLE = 1;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/mux_scan_capture.sv
// N-bit capture register: writes one sampled bit per strobe, loads the
// finished word to the output. Parity with MUX_SCAN_SAMPLER_PARITY_EN.
module mux_scan_capture
    import mux_scan_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr,
    input  logic [SEL_W-1:0]        idx,
    input  logic                    bit_in,
    input  logic                    load,
`ifdef MUX_SCAN_SAMPLER_PARITY_EN
    output logic                    parity,
`endif
    output logic [(2**SEL_W)-1:0]   word
);

    localparam int N = 2**SEL_W;

    logic [N-1:0] shift_q;
    logic [N-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (wr) begin
            shift_d[idx] = bit_in;
        end
    end

    // The loaded word includes the bit written on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            word    <= '0;
        end else begin
            shift_q <= shift_d;
            if (load) begin
                word <= shift_d;
            end
        end
    end

`ifdef MUX_SCAN_SAMPLER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (load) begin
            parity <= ^shift_d;
        end
    end
`endif

endmodule

// File: rtl/mux_scan_sampler.sv
// Scans a 2**SEL_W:1 mux, samples iY after SETTLE cycles, emits a word.
// Optional oParity output is enabled with MUX_SCAN_SAMPLER_PARITY_EN.
module mux_scan_sampler
    import mux_scan_pkg::*;
#(
    parameter int SEL_W  = DEF_SEL_W,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                    iCLK,
    input  logic                    iRST_n,
    input  logic                    iStart,
    output logic [SEL_W-1:0]        oSel,
    input  logic                    iY,
    output logic [(2**SEL_W)-1:0]   oData,
    output logic                    oValid,
    input  logic                    iReady,
`ifdef MUX_SCAN_SAMPLER_PARITY_EN
    output logic                    oParity,
`endif
    output logic                    oBusy
);

    localparam int N = 2**SEL_W;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam state_t ST_FIRST =
        (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             cap_wr;
    logic             cap_load;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        cap_wr   = 1'b0;
        cap_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    sel_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_FIRST;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                cap_wr = 1'b1;
                if (sel_q == SEL_LAST) begin
                    cap_load = 1'b1;
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                    sel_d    = '0;
                    state_d  = ST_HOLD;
                end else begin
                    sel_d   = sel_q + SEL_W'(1);
                    state_d = ST_FIRST;
                end
            end
            ST_HOLD: begin
                // A start on the accept edge chains straight into a new scan.
                if (iReady) begin
                    valid_d = 1'b0;
                    if (iStart) begin
                        sel_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = ST_FIRST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    mux_scan_capture #(
        .SEL_W (SEL_W)
    ) u_capture (
        .clk    (iCLK),
        .rst_n  (iRST_n),
        .wr     (cap_wr),
        .idx    (sel_q),
        .bit_in (iY),
        .load   (cap_load),
`ifdef MUX_SCAN_SAMPLER_PARITY_EN
        .parity (oParity),
`endif
        .word   (oData)
    );

    assign oSel   = sel_q;
    assign oValid = valid_q;
    assign oBusy  = busy_q;

endmodule

// File: doc/mux_scan_sampler.md
Name: mux_scan_sampler

Overview:
- Upstream/downstream companion of the 8:1 multiplexer stage.
- Drives the mux select lines through all 2**SEL_W channels in order and samples the single-bit mux output after a programmable settle time.
- Packs the samples into a word and presents it downstream with a valid/ready handshake.
- Sits between the mux stage and any word-wide consumer, and turns the combinational mux into a scanned input port.

Parameters:
- SEL_W, 3: select width; scan length N = 2**SEL_W channels; oData width = N.
- SETTLE, 1: wait cycles after each select change before sampling iY; 0 is legal, max 15.

Ports:
- iCLK, input, 1: clock, rising edge.
- iRST_n, input, 1: asynchronous active-low reset.
- iStart, input, 1: scan request; sampled only in IDLE.
- oSel, output, SEL_W: mux select; bit 0 drives the mux LSB select input.
- iY, input, 1: mux output being sampled.
- oData, output, N: assembled word; bit k = iY captured while oSel==k.
- oValid, output, 1: oData is valid and held.
- iReady, input, 1: consumer accepts oData when oValid & iReady.
- oBusy, output, 1: scan in progress.

Behaviour:
- Reset (async assert, sync release): state=IDLE; oSel=0; oData=0; oValid=0; oBusy=0; internal counters=0.
- States: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE:
  - On an edge with iStart=1: oSel=0, oBusy=1.
  - Next state is SETTLE, or SAMPLE if SETTLE==0.
- SETTLE: counts SETTLE cycles with oSel constant, then goes to SAMPLE.
- SAMPLE: on the edge, capture iY into shift-register bit oSel.
  - If oSel < N-1: oSel increments, next state is SETTLE (or SAMPLE if SETTLE==0).
  - If oSel == N-1: the shift register is copied to oData, oValid=1, oBusy=0, oSel returns to 0, next state is HOLD.
- Latency: if iStart is seen at edge E0, bit k is captured at edge E0+(k+1)*(SETTLE+1) and oValid rises at E0+N*(SETTLE+1). Default: 16 cycles.
- HOLD:
  - oData and oValid are held stable until oValid & iReady.
  - On accept: oValid=0 and the next state is IDLE.
  - If iStart=1 on the same accept edge, a new scan starts directly: oBusy=1, oSel=0, same timing as from IDLE.
- iStart outside IDLE (and outside the HOLD accept edge) is ignored; it is not queued.
- iReady without oValid has no effect.
- oData changes only on a scan-complete edge; partial scans are never visible on oData.
- Reset mid-scan aborts immediately; the partial word is discarded and oData returns to 0.
- oSel wraps N-1 to 0 only at scan completion; it never overflows.

Optional Feature:
- Macro: MUX_SCAN_SAMPLER_PARITY_EN.
- With the macro defined:
  - An extra output oParity (1 bit) equals the XOR of all bits of the word loaded into oData.
  - It is registered on the same edge as oValid and held with it.
  - Reset value is 0.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include mux_scan_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_SAMPLE=2'd2, ST_HOLD=2'd3;
  - default SEL_W and SETTLE;
  - settle-counter width constant (4).
- One sub-module, mux_scan_capture: N-bit capture register with write-bit-at-index and load-to-output strobes.
- The FSM, select counter and settle counter stay in the top module.

Test Plan:
- Basic scan: behavioural 8:1 mux model with inputs 8'hA5, iStart pulse, SETTLE=1 -> oValid rises exactly 16 cycles later; oData=8'hA5; oSel steps 0..7, each value held 2 cycles.
- SETTLE=0, mux inputs 8'h3C -> oSel changes every cycle; oValid rises after 8 cycles; oData=8'h3C.
- Backpressure: iReady=0 for 5 cycles after oValid -> oValid and oData held; iStart during the hold is ignored (oBusy stays 0); iReady=1 -> oValid drops next edge.
- Back-to-back: iStart=1 on the accept edge with inputs changed to 8'h0F -> no IDLE gap; second oValid after 16 cycles with oData=8'h0F.
- Reset mid-scan: iRST_n low at cycle 7 of the scan -> oSel, oData, oValid, oBusy go to 0 immediately (asynchronously); a fresh scan afterwards returns the correct word.
- Parity build: inputs 8'hA5 -> oParity=0; inputs 8'hA4 -> oParity=1, asserted together with oValid.
